// File: rtl/riscv_pkg.sv
// Shared types for the instruction-memory loader: loader FSM states and header size.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Fills the instruction memory from a framed byte stream (32-bit MSB-first length, then payload)
// and keeps the core in reset until the whole image has been written.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int PRACTICAL_WIDTH = 20,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     cpu_hold
);

    localparam int          CNT_W   = $clog2(LEN_BYTES);
    localparam logic [31:0] MAX_LEN = 32'd1 << PRACTICAL_WIDTH;

    loader_state_t          state, state_nxt;
    logic [CNT_W-1:0]       byte_cnt;
    logic [31:0]            len_q;
    logic [31:0]            len_shift;
    logic [PRACTICAL_WIDTH:0] addr_cnt;
    logic                   accept;
    logic                   last_hdr;
    logic                   last_data;

    assign accept    = in_valid && in_ready;
    assign len_shift = {len_q[31-DATA_WIDTH:0], in_data};
    assign last_hdr  = (byte_cnt == CNT_W'(LEN_BYTES - 1));
    assign last_data = ((32'(addr_cnt) + 32'd1) == len_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                if (accept && last_hdr) begin
                    if (len_shift == 32'd0)         state_nxt = DONE;
                    else if (len_shift > MAX_LEN)   state_nxt = ERR;
                    else                            state_nxt = DATA;
                end
            end
            DATA: begin
                if (accept && last_data) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is registered from the next state so it is high exactly while in LEN or DATA
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == LEN) || (state_nxt == DATA);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            addr_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_cnt <= '0;
                        len_q    <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        len_q    <= len_shift;
                        byte_cnt <= byte_cnt + 1'b1;
                        addr_cnt <= '0;
                    end
                end
                DATA: begin
                    if (accept) addr_cnt <= addr_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // write stage: one register between an accepted payload byte and the memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= (state == DATA) && accept;
            if ((state == DATA) && accept) begin
                waddr <= ADDRESS_WIDTH'(addr_cnt);
                wdata <= in_data;
            end
        end
    end

    assign busy     = (state == LEN) || (state == DATA);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_hold = (state != DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the byte-addressed instruction ROM; fills its backing byte array from a byte stream (UART/debug bridge) before the core runs.
- Receives a framed stream: 4-byte length header, MSB first, then payload bytes.
- Writes payload to consecutive byte addresses from 0 through a synchronous byte write port.
- Holds the CPU in reset until the load completes.
- Byte order matches the fetch path: byte at address A is instruction bits [31:24].

Parameters:
ADDRESS_WIDTH, 32, width of write address output
PRACTICAL_WIDTH, 20, log2 of implemented memory bytes; loads larger than 2**PRACTICAL_WIDTH bytes are rejected
DATA_WIDTH, 8, byte width of stream and write port

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; begins a new load
in_valid  in  1  stream byte valid
in_data  in  DATA_WIDTH  stream byte
in_ready  out  1  loader can accept a byte
we  out  1  memory write enable, one byte per cycle
waddr  out  ADDRESS_WIDTH  memory byte address
wdata  out  DATA_WIDTH  memory write data
busy  out  1  load in progress (LEN or DATA)
done  out  1  sticky; last load completed successfully
err  out  1  sticky; last load rejected (length too large)
cpu_hold  out  1  holds core in reset; low only in DONE

Behaviour:
- States: IDLE, LEN, DATA, DONE, ERR.
- Reset values: state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_hold=1.
- Reset mid-load returns to IDLE with no further writes; memory contents already written are left as-is.
- Accept: in_valid && in_ready on a rising edge. in_ready=1 only in LEN and DATA, as a registered function of state. in_data is ignored in all other states.

State transitions:
- IDLE: start -> LEN; byte counter=0, length register=0.
- DONE or ERR: start -> LEN; clears done and err.
- LEN, DATA: start is ignored.
- LEN: each accepted byte shifts into length, MSB first (len <= {len[23:0], in_data}). On the 4th accept:
  - length == 0 -> DONE;
  - length > 2**PRACTICAL_WIDTH -> ERR;
  - otherwise -> DATA with addr counter=0.
- DATA: each accepted byte produces, on the next cycle, we=1, waddr=addr counter (zero-extended), wdata=byte. Write latency is exactly 1 cycle. The addr counter increments per accept. Back-to-back accepts give back-to-back writes with no bubbles.
- DATA exit: after the accept of byte number length, state -> DONE in the same edge. That final write still appears on the cycle the state is DONE.

Outputs and arithmetic:
- busy = state in {LEN, DATA}. done=1 in DONE, err=1 in ERR, each cleared by start.
- cpu_hold=0 only in DONE. It deasserts on the same cycle as the final we pulse; the memory write is committed at that edge, before the first fetch.
- length register is 32 bits; addr counter is PRACTICAL_WIDTH+1 bits. Address wrap cannot occur because oversize lengths go to ERR.
- length == 2**PRACTICAL_WIDTH is legal and fills memory exactly.

Decomposition:
- Shared package riscv_pkg: loader_state_t enum (IDLE, LEN, DATA, DONE, ERR) and LEN_BYTES=4.
- No sub-module. The write stage is a single register stage inside the block.
- The target memory (writable variant of the ROM array) is a separate block and out of scope.

Test Plan:
- Reset, then stream 00 00 00 04 DE AD BE EF with in_valid held high. Writes (0,DE),(1,AD),(2,BE),(3,EF) on consecutive cycles. Fetch-side word at 0 = 32'hDEADBEEF. done=1, cpu_hold=0 on the last write cycle.
- Header 00 00 00 00 -> DONE directly after the 4th byte; no we pulse; done=1.
- Header 00 10 00 01 (2**20+1) with PRACTICAL_WIDTH=20 -> err=1, in_ready=0, cpu_hold=1, no writes. Then start -> err=0, state LEN.
- Length 3 with in_valid toggling 1,0,1,0,1 -> exactly 3 writes to addresses 0,1,2; no write in stall cycles; waddr never skips.
- Assert rst after the 2nd payload byte of a length-8 load -> next cycle we=0, busy=0, cpu_hold=1, in_ready=0. Subsequent in_valid bytes produce no writes.
- start pulsed while in DATA -> ignored; counter and length unchanged; load completes normally.
